// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port, variable-latency memory between the IF stage and
// the MEM stage. One outstanding access at a time; data wins ties unless IF
// has lost STARVE_LIMIT arbitrations in a row. Completion is signalled by a
// one-cycle ready pulse to the owner, and the global pipeline stall is
// derived from the outstanding requests.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   if_req/if_addr        fetch request (held until if_ready) and byte address
//   if_rdata/if_ready     fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr     data request (held until d_ready), store flag, address
//   d_wdata/d_be          store data and byte enables
//   d_rdata/d_ready       load data (0 for stores) and completion pulse
//   mem_req               memory strobe, held until mem_ack
//   mem_we/addr/wdata/be  registered access payload
//   mem_ack/mem_rdata     memory completion and read data (same cycle)
//   pipe_stall            combinational stall for the pipeline registers
//   err_spurious_ack      sticky flag: mem_ack seen while no access in flight
module unified_mem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            pipe_stall,
    output logic            err_spurious_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t          r_state;
    owner_t          r_owner;
    logic [3:0]      r_starve_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_d_rdata;
    logic            r_if_ready;
    logic            r_d_ready;
    logic            r_err;

    logic            w_grant_if;

    // IF wins only when alone, or on a tie once it has been starved enough.
    assign w_grant_if = if_req & (~d_req | (r_starve_cnt == LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_ready   <= 1'b0;
            r_d_ready    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Ready is a single-cycle pulse: only the BUSY->RESP edge sets it.
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;

            if (mem_ack && (r_state != ST_BUSY)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (if_req || d_req) begin
                        r_mem_req <= 1'b1;
                        r_state   <= ST_BUSY;
                        if (w_grant_if) begin
                            r_owner      <= OWN_IF;
                            r_mem_we     <= 1'b0;
                            r_mem_addr   <= if_addr;
                            r_mem_wdata  <= '0;
                            r_mem_be     <= 4'hF;
                            r_starve_cnt <= '0;
                        end else begin
                            r_owner     <= OWN_D;
                            r_mem_we    <= d_we;
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                            r_mem_be    <= d_be;
                            if (if_req && (r_starve_cnt != LIMIT)) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= mem_rdata;
                            r_if_ready <= 1'b1;
                        end else begin
                            r_d_rdata <= r_mem_we ? '0 : mem_rdata;
                            r_d_ready <= 1'b1;
                        end
                    end
                end
                // Back to IDLE unconditionally so a request still held
                // during its ready cycle is not granted a second time.
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign if_rdata         = r_if_rdata;
    assign if_ready         = r_if_ready;
    assign d_rdata          = r_d_rdata;
    assign d_ready          = r_d_ready;
    assign mem_req          = r_mem_req;
    assign mem_we           = r_mem_we;
    assign mem_addr         = r_mem_addr;
    assign mem_wdata        = r_mem_wdata;
    assign mem_be           = r_mem_be;
    assign err_spurious_ack = r_err;

    assign pipe_stall = (if_req & ~r_if_ready) | (d_req & ~r_d_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
// Randomized requesters and a variable-latency memory drive the arbiter.
// A transaction-level reference (grant rule, starvation count, word memory
// with byte-enable merges) predicts every output each cycle.
module tb_unified_mem_arbiter;

    localparam int unsigned LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, pipe_stall, err_spurious_ack;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pipe_stall(pipe_stall), .err_spurious_ack(err_spurious_ack)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference memory (what requesters should observe) and the memory
    // device contents (written from whatever the DUT presents).
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] env_mem[int unsigned];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rd_env(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Reference timeline: 0 = arbiter free, 1 = access in flight, 2 = reply cycle.
    int          ph;
    bit          own_d;
    int unsigned starve;
    bit          exp_err;
    bit          ir, dr, dwe;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    bit          if_rel, d_rel;
    int unsigned if_pct, d_pct, lat_min, lat_max;
    bit          acc_act, ack_drv;
    int unsigned acc_cnt;
    bit          grants[$];

    function automatic logic [31:0] rand_addr();
        return 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    task automatic drive();
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_be    = dbe;
        mem_ack = ack_drv;
    endtask

    task automatic step();
        bit          exp_ifr, exp_dr;
        logic [31:0] exp_rd;
        @(posedge clk);
        #1;
        exp_ifr = 0;
        exp_dr  = 0;
        exp_rd  = '0;
        if (ack_drv && ph != 1) exp_err = 1;
        case (ph)
            0: if (ir || dr) begin
                own_d = dr && !(ir && starve == LIMIT);
                if (!own_d) starve = 0;
                else if (ir && starve < LIMIT) starve++;
                grants.push_back(own_d);
                ph = 1;
            end
            1: if (ack_drv) begin
                ph = 2;
                if (own_d) begin
                    exp_dr = 1;
                    if (dwe) ref_mem[da] = merge(rd_ref(da), dwd, dbe);
                    else exp_rd = rd_ref(da);
                end else begin
                    exp_ifr = 1;
                    exp_rd  = rd_ref(ia);
                end
            end
            default: ph = 0;
        endcase

        check("mem_req", 32'(mem_req), 32'(ph == 1));
        if (ph == 1) begin
            if (own_d) begin
                check("mem_we_d", 32'(mem_we), 32'(dwe));
                check("mem_addr_d", mem_addr, da);
                check("mem_wdata_d", mem_wdata, dwd);
                check("mem_be_d", 32'(mem_be), 32'(dbe));
            end else begin
                check("mem_we_if", 32'(mem_we), 32'd0);
                check("mem_addr_if", mem_addr, ia);
                check("mem_be_if", 32'(mem_be), 32'hF);
            end
        end
        check("if_ready", 32'(if_ready), 32'(exp_ifr));
        check("d_ready", 32'(d_ready), 32'(exp_dr));
        if (exp_ifr) check("if_rdata", if_rdata, exp_rd);
        if (exp_dr) check("d_rdata", d_rdata, exp_rd);
        check("err_spurious_ack", 32'(err_spurious_ack), 32'(exp_err));

        // Requesters hold through their ready cycle, then may issue anew.
        if (ir && exp_ifr) if_rel = 1;
        else if (if_rel || !ir) begin
            if_rel = 0;
            ir = ($urandom_range(0, 99) < if_pct);
            if (ir) ia = rand_addr();
        end
        if (dr && exp_dr) d_rel = 1;
        else if (d_rel || !dr) begin
            d_rel = 0;
            dr = ($urandom_range(0, 99) < d_pct);
            if (dr) begin
                dwe = 1'($urandom_range(0, 1));
                da  = rand_addr();
                dwd = $urandom;
                dbe = dwe ? 4'($urandom_range(1, 15)) : 4'hF;
            end
        end

        // Memory device: acks after a random wait, returns garbage otherwise.
        ack_drv   = 0;
        mem_rdata = $urandom;
        if (mem_req) begin
            if (!acc_act) begin
                acc_act = 1;
                acc_cnt = $urandom_range(lat_min, lat_max);
            end
            if (acc_cnt == 0) begin
                ack_drv   = 1;
                acc_act   = 0;
                mem_rdata = rd_env(mem_addr);
                if (mem_we) env_mem[mem_addr] = merge(rd_env(mem_addr), mem_wdata, mem_be);
            end else acc_cnt--;
        end
        drive();
        #1;
        check("pipe_stall", 32'(pipe_stall), 32'((ir && !exp_ifr) || (dr && !exp_dr)));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        check({tag, "_if_ready"}, 32'(if_ready), 32'd0);
        check({tag, "_d_ready"}, 32'(d_ready), 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_err"}, 32'(err_spurious_ack), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1;
        ir = 0; dr = 0; dwe = 0; ia = '0; da = '0; dwd = '0; dbe = '0;
        ack_drv = 0; acc_act = 0; acc_cnt = 0; if_rel = 0; d_rel = 0;
        ph = 0; starve = 0; exp_err = 0;
        mem_rdata = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_pipe_stall", 32'(pipe_stall), 32'd0);
        rst = 0;
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        for (int i = 0; i < 40; i++) begin
            if (ph == 0 && !ir && !dr) begin
                idle = 1;
                break;
            end
            step();
        end
        check("drain_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [4:0]  gseq;
        if_pct = 0; d_pct = 0; lat_min = 0; lat_max = 0;
        do_reset();

        // Reset while an access is in flight.
        ir = 1; ia = 32'h10; drive();
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) seen = 1;
        end
        check("busy_reached", 32'(seen), 32'd1);
        #2;
        rst = 1;
        #1;
        check_outputs_zero("async_rst");
        do_reset();

        // Single fetch with one-cycle memory.
        ref_mem[32'h10] = 32'h0050_0093;
        env_mem[32'h10] = 32'h0050_0093;
        ir = 1; ia = 32'h10; drive();
        repeat (5) step();

        // Store and fetch contending; the fetch reads back the stored word.
        lat_max = 2;
        dr = 1; dwe = 1; da = 32'h40; dwd = 32'hDEAD_BEEF; dbe = 4'hF;
        ir = 1; ia = 32'h40; drive();
        repeat (12) step();
        drain();

        // Anti-starvation: both always requesting from a cleared counter.
        do_reset();
        grants.delete();
        if_pct = 100; d_pct = 100; lat_max = 1;
        for (int i = 0; i < 60 && grants.size() < 5; i++) step();
        check("starve_grants", grants.size(), 32'd5);
        if (grants.size() >= 5) begin
            gseq = {grants[0], grants[1], grants[2], grants[3], grants[4]};
            check("starve_seq", 32'(gseq), 32'b11101);
        end
        if_pct = 0; d_pct = 0;
        drain();

        // Load with a five-cycle memory wait.
        ref_mem[32'h80] = 32'h1234_5678;
        env_mem[32'h80] = 32'h1234_5678;
        lat_min = 5; lat_max = 5;
        dr = 1; dwe = 0; da = 32'h80; dbe = 4'hF; drive();
        repeat (10) step();
        drain();

        // Random traffic.
        if_pct = 50; d_pct = 50; lat_min = 0; lat_max = 4;
        repeat (1500) step();
        if_pct = 0; d_pct = 0;
        drain();

        // Spurious ack while idle, then traffic with the sticky flag set.
        ack_drv = 1; drive();
        step();
        if_pct = 40; d_pct = 40;
        repeat (200) step();
        if_pct = 0; d_pct = 0;
        drain();
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
